seg7_scan_reader: RTL and testbench



---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_pattern_decode.sv | 30 +++
 rtl/seg7_scan_reader.sv | 191 +++++++++++++++++++
 tb/tb_seg7_scan_reader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low glyphs (bit 0 = segment a), the
// blank BCD code and the state encodings used by the scan reader.
package seg7_pkg;

    localparam logic [6:0] SEG7_0     = 7'b1000000;
    localparam logic [6:0] SEG7_1     = 7'b1111001;
    localparam logic [6:0] SEG7_2     = 7'b0100100;
    localparam logic [6:0] SEG7_3     = 7'b0110000;
    localparam logic [6:0] SEG7_4     = 7'b0011001;
    localparam logic [6:0] SEG7_5     = 7'b0010010;
    localparam logic [6:0] SEG7_6     = 7'b0000010;
    localparam logic [6:0] SEG7_7     = 7'b1111000;
    localparam logic [6:0] SEG7_8     = 7'b0000000;
    localparam logic [6:0] SEG7_9     = 7'b0010000;
    localparam logic [6:0] SEG7_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HELD  = 2'd2
    } stab_state_e;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Inverse of the display encoder: active-low segment pattern to BCD digit.
// Blank decodes to BCD_BLANK without error; any unknown glyph flags an error.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] code_o,
    output logic       err_o
);

    always_comb begin
        code_o = BCD_BLANK;
        err_o  = 1'b0;
        case (pattern_i)
            SEG7_0:     code_o = 4'd0;
            SEG7_1:     code_o = 4'd1;
            SEG7_2:     code_o = 4'd2;
            SEG7_3:     code_o = 4'd3;
            SEG7_4:     code_o = 4'd4;
            SEG7_5:     code_o = 4'd5;
            SEG7_6:     code_o = 4'd6;
            SEG7_7:     code_o = 4'd7;
            SEG7_8:     code_o = 4'd8;
            SEG7_9:     code_o = 4'd9;
            SEG7_BLANK: code_o = BCD_BLANK;
            default:    err_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads back a multiplexed active-low 7-segment bus into packed BCD frames.
// Define SEG7_READER_SYNC_EN to put a two-flop synchronizer ahead of the sampling register.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    output logic [4*DIGITS-1:0]   value_bcd,
    output logic [DIGITS-1:0]     value_err,
    output logic                  value_valid,
    input  logic                  value_ready,
    output logic                  frame_overrun
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [6:0]        seg_s_q;
    logic [DIGITS-1:0] an_s_q;

`ifdef SEG7_READER_SYNC_EN
    logic [6:0]        seg_m1_q, seg_m2_q;
    logic [DIGITS-1:0] an_m1_q, an_m2_q;

    // Two synchronizer flops, then the sampling register.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_m1_q <= '1;
            an_m2_q <= '1;
            an_s_q  <= '1;
        end else begin
            an_m1_q <= an_n;
            an_m2_q <= an_m1_q;
            an_s_q  <= an_m2_q;
        end
        seg_m1_q <= seg_n;
        seg_m2_q <= seg_m1_q;
        seg_s_q  <= seg_m2_q;
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            an_s_q <= '1;
        end else begin
            an_s_q <= an_n;
        end
        seg_s_q <= seg_n;
    end
`endif

    logic             smp_valid;
    logic [IDX_W-1:0] smp_idx;
    logic [DIGITS-1:0] an_low;

    always_comb begin
        an_low    = ~an_s_q;
        smp_valid = $onehot(an_low);
        smp_idx   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_low[i]) smp_idx = IDX_W'(i);
        end
    end

    stab_state_e      st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [6:0]       pat_q, pat_d;
    logic             same_smp;
    logic             accept;

    assign same_smp = smp_valid && (smp_idx == idx_q) && (seg_s_q == pat_q);

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        pat_d  = pat_q;
        accept = 1'b0;
        if (!smp_valid) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
        end else if (st_q == ST_IDLE || !same_smp) begin
            // Any new (digit, pattern) pair starts a fresh dwell.
            st_d  = ST_TRACK;
            cnt_d = CNT_W'(1);
            idx_d = smp_idx;
            pat_d = seg_s_q;
        end else if (st_q == ST_TRACK) begin
            if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                accept = 1'b1;
                st_d   = ST_HELD;
                cnt_d  = CNT_W'(STABLE_CYCLES);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= ST_IDLE;
            cnt_q <= '0;
            idx_q <= '0;
            pat_q <= '1;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            pat_q <= pat_d;
        end
    end

    logic [3:0] dec_code;
    logic       dec_err;

    seg7_pattern_decode u_decode (
        .pattern_i (pat_q),
        .code_o    (dec_code),
        .err_o     (dec_err)
    );

    logic [4*DIGITS-1:0] shadow_bcd_q;
    logic [DIGITS-1:0]   shadow_err_q;
    logic [DIGITS-1:0]   mask_q, mask_d;
    out_state_e          out_st_q, out_st_d;
    logic [4*DIGITS-1:0] bcd_q;
    logic [DIGITS-1:0]   err_q;
    logic                ovr_q, ovr_d;
    logic                consume, complete, load_out;

    assign consume  = (out_st_q == OUT_FULL) && value_ready;
    assign complete = &mask_q;

    always_comb begin
        mask_d   = mask_q;
        out_st_d = out_st_q;
        load_out = 1'b0;
        ovr_d    = 1'b0;
        if (complete) begin
            mask_d = '0;
            if (out_st_q == OUT_EMPTY || consume) begin
                load_out = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        // An accept landing with a completion belongs to the next frame.
        if (accept) mask_d[idx_q] = 1'b1;
        if (load_out) begin
            out_st_d = OUT_FULL;
        end else if (consume) begin
            out_st_d = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            shadow_bcd_q[4*idx_q +: 4] <= dec_code;
            shadow_err_q[idx_q]        <= dec_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q   <= '0;
            out_st_q <= OUT_EMPTY;
            bcd_q    <= '0;
            err_q    <= '0;
            ovr_q    <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            out_st_q <= out_st_d;
            ovr_q    <= ovr_d;
            if (load_out) begin
                bcd_q <= shadow_bcd_q;
                err_q <= shadow_err_q;
            end
        end
    end

    assign value_bcd     = bcd_q;
    assign value_err     = err_q;
    assign value_valid   = (out_st_q == OUT_FULL);
    assign frame_overrun = ovr_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: run-length reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_seg7_scan_reader;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;
`ifdef SEG7_READER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  an_n = 4'hF;
    logic [15:0] value_bcd;
    logic [3:0]  value_err;
    logic        value_valid;
    logic        value_ready = 1'b0;
    logic        frame_overrun;

    int total = 0;
    int bad   = 0;
    int ovr_seen = 0;
    bit chk_en = 1'b0;

    logic [6:0] glyph [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

    always #5 clk = ~clk;

    seg7_scan_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .seg_n         (seg_n),
        .an_n          (an_n),
        .value_bcd     (value_bcd),
        .value_err     (value_err),
        .value_valid   (value_valid),
        .value_ready   (value_ready),
        .frame_overrun (frame_overrun)
    );

    // Reference model: a digit is accepted when its (digit, pattern) pair has been
    // seen for exactly STABLE consecutive samples; frames complete when all digits arrived.
    logic [6:0]  h_seg [0:2];
    logic [3:0]  h_an  [0:2];
    int          run, run_d, pend_d, nlow, sd;
    logic [6:0]  run_seg, s_seg;
    logic [3:0]  s_an;
    bit          pend, pend_e, m_consume;
    logic [3:0]  pend_code;
    logic [15:0] m_bcd, m_sh_bcd;
    logic [3:0]  m_err, m_sh_err, m_mask;
    bit          m_valid, m_ovr;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin h_seg[i] = 7'h7F; h_an[i] = 4'hF; end
            run = 0; pend = 0; m_bcd = '0; m_err = '0; m_mask = '0;
            m_valid = 0; m_ovr = 0;
        end else begin
            for (int i = 2; i > 0; i--) begin h_seg[i] = h_seg[i-1]; h_an[i] = h_an[i-1]; end
            h_seg[0] = seg_n;
            h_an[0]  = an_n;
            m_consume = m_valid && value_ready;
            m_ovr = 0;
            if (m_mask == 4'hF) begin
                m_mask = '0;
                if (!m_valid || m_consume) begin
                    m_bcd = m_sh_bcd; m_err = m_sh_err; m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_consume) begin
                m_valid = 0;
            end
            if (pend) begin
                m_sh_bcd[4*pend_d +: 4] = pend_code;
                m_sh_err[pend_d] = pend_e;
                m_mask[pend_d] = 1'b1;
                pend = 0;
            end
            s_an  = h_an[LAT];
            s_seg = h_seg[LAT];
            nlow  = $countones(~s_an);
            if (nlow == 1) begin
                sd = 0;
                for (int i = 0; i < 4; i++) if (!s_an[i]) sd = i;
                if (run > 0 && sd == run_d && s_seg == run_seg) run = run + 1;
                else begin run = 1; run_d = sd; run_seg = s_seg; end
                if (run == STABLE) begin
                    pend = 1; pend_d = sd; pend_code = 4'hF;
                    pend_e = (s_seg != 7'h7F);
                    for (int g = 0; g < 10; g++) begin
                        if (glyph[g] == s_seg) begin pend_code = 4'(g); pend_e = 0; end
                    end
                end
            end else begin
                run = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_en) begin
            chk("model", {9'd0, value_bcd, value_err, value_valid, frame_overrun},
                {9'd0, m_bcd, m_err, m_valid, m_ovr});
        end
        if (frame_overrun) ovr_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic dwell(input int d, input logic [6:0] pat, input int n);
        logic [3:0] one;
        one   = 4'b0001;
        an_n  = ~(one << d);
        seg_n = pat;
        repeat (n) step();
    endtask

    task automatic idle(input int n);
        an_n  = 4'hF;
        seg_n = 7'h7F;
        repeat (n) step();
    endtask

    task automatic frame(input int d3, input int d2, input int d1, input int d0);
        dwell(3, glyph[d3], 6);
        dwell(2, glyph[d2], 6);
        dwell(1, glyph[d1], 6);
        dwell(0, glyph[d0], 6);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    int ovr_base;

    initial begin
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step();
        chk("reset_bcd", 32'(value_bcd), 32'h0);
        chk("reset_flags", {28'd0, value_err}, 32'h0);
        chk("reset_valid", {31'd0, value_valid}, 32'h0);
        rst = 1'b0;
        idle(2);

        // Basic frame with a consumer that is always ready.
        value_ready = 1'b1;
        dwell(3, glyph[4], 6);
        dwell(2, glyph[7], 6);
        dwell(1, glyph[0], 6);
        dwell(0, glyph[9], 5);
        chk("s1_valid_early", {31'd0, value_valid}, 32'h0);
        step();
        chk("s1_valid", {31'd0, value_valid}, 32'h1);
        chk("s1_bcd", 32'(value_bcd), 32'h4709);
        chk("s1_err", {28'd0, value_err}, 32'h0);
        step();
        chk("s1_valid_drop", {31'd0, value_valid}, 32'h0);
        idle(3);

        // Too-short dwell on digit 2 never completes a frame.
        pulse_rst();
        value_ready = 1'b0;
        dwell(3, glyph[1], 6);
        dwell(2, glyph[2], 3);
        dwell(1, glyph[3], 6);
        dwell(0, glyph[4], 6);
        idle(8);
        chk("s2_no_valid", {31'd0, value_valid}, 32'h0);

        // Illegal glyph on digit 2, blank on digit 1.
        pulse_rst();
        dwell(3, glyph[1], 6);
        dwell(2, 7'b0101010, 6);
        dwell(1, 7'b1111111, 6);
        dwell(0, glyph[5], 6);
        idle(2);
        chk("s3_bcd", 32'(value_bcd), 32'h1FF5);
        chk("s3_err", {28'd0, value_err}, 32'h4);
        value_ready = 1'b1;
        step();
        chk("s3_consumed", {31'd0, value_valid}, 32'h0);
        value_ready = 1'b0;

        // Second frame while the first is still held: one overrun.
        pulse_rst();
        ovr_base = ovr_seen;
        frame(1, 2, 3, 4);
        frame(5, 6, 7, 8);
        idle(3);
        chk("s4_ovr_count", 32'(ovr_seen - ovr_base), 32'h1);
        chk("s4_held_bcd", 32'(value_bcd), 32'h1234);
        chk("s4_held_valid", {31'd0, value_valid}, 32'h1);
        value_ready = 1'b1;
        step();
        chk("s4_consumed", {31'd0, value_valid}, 32'h0);
        value_ready = 1'b0;

        // Handshake in the same cycle as a completion.
        pulse_rst();
        ovr_base = ovr_seen;
        frame(1, 2, 3, 4);
        idle(2);
        dwell(3, glyph[5], 6);
        dwell(2, glyph[6], 6);
        dwell(1, glyph[7], 6);
        dwell(0, glyph[8], 5);
        chk("s5_old_bcd", 32'(value_bcd), 32'h1234);
        value_ready = 1'b1;
        step();
        value_ready = 1'b0;
        chk("s5_valid_kept", {31'd0, value_valid}, 32'h1);
        chk("s5_new_bcd", 32'(value_bcd), 32'h5678);
        idle(3);
        chk("s5_no_ovr", 32'(ovr_seen - ovr_base), 32'h0);
        value_ready = 1'b1;
        step();
        chk("s5_consumed", {31'd0, value_valid}, 32'h0);
        value_ready = 1'b0;

        // Illegal double select mid-dwell, then reset mid-frame.
        pulse_rst();
        frame(9, 8, 7, 6);
        idle(2);
        chk("s6_pre_valid", {31'd0, value_valid}, 32'h1);
        dwell(3, glyph[1], 6);
        dwell(2, glyph[2], 2);
        an_n = 4'b0011;
        repeat (4) step();
        dwell(2, glyph[2], 2);
        pulse_rst();
        chk("s6_rst_bcd", 32'(value_bcd), 32'h0);
        chk("s6_rst_valid", {30'd0, value_valid, frame_overrun}, 32'h0);
        dwell(2, glyph[8], 6);
        dwell(1, glyph[3], 6);
        dwell(0, glyph[6], 6);
        idle(3);
        chk("s6_partial", {31'd0, value_valid}, 32'h0);
        dwell(3, glyph[1], 6);
        idle(2);
        chk("s6_fresh_bcd", 32'(value_bcd), 32'h1836);
        chk("s6_fresh_valid", {31'd0, value_valid}, 32'h1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
